// File: rtl/bsg_fifo_tracker_multi.sv
// Pointer/occupancy tracker for a circular FIFO of arbitrary depth that accepts
// up to max_add_p enqueues and dequeues per cycle, with sticky error reporting.
module bsg_fifo_tracker_multi #(
  parameter int els_p                 = 1024,
  parameter int max_add_p             = 1,
  parameter int almost_full_margin_p  = 1,
  parameter int almost_empty_margin_p = 1,
  localparam int ptr_w = ($clog2(els_p) > 1) ? $clog2(els_p) : 1,
  localparam int cnt_w = $clog2(els_p + 1),
  localparam int add_w = $clog2(max_add_p + 1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [add_w-1:0] enq_i,
  input  logic [add_w-1:0] deq_i,
  output logic [ptr_w-1:0] wptr_r_o,
  output logic [ptr_w-1:0] rptr_r_o,
  output logic [ptr_w-1:0] rptr_n_o,
  output logic [cnt_w-1:0] count_r_o,
  output logic [cnt_w-1:0] free_r_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int sum_w = ptr_w + 1;
  localparam logic [sum_w-1:0] els_sum_lp = sum_w'(els_p);
  localparam logic [cnt_w-1:0] els_cnt_lp = cnt_w'(els_p);
  localparam logic [31:0] af_margin_lp = 32'(almost_full_margin_p);
  localparam logic [31:0] ae_margin_lp = 32'(almost_empty_margin_p);
  localparam logic [31:0] max_add_lp   = 32'(max_add_p);

  logic [ptr_w-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             enq_ok, deq_ok, legal;
  logic [sum_w-1:0] wsum, rsum;

  // A single conditional subtract is enough because one step never exceeds els_p.
  function automatic logic [ptr_w-1:0] wrap(input logic [sum_w-1:0] x);
    return (x >= els_sum_lp) ? ptr_w'(x - els_sum_lp) : ptr_w'(x);
  endfunction

  always_comb begin
    enq_ok      = (32'(enq_i) <= 32'(free_r_o));
    deq_ok      = (32'(deq_i) <= 32'(count_q));
    legal       = enq_ok & deq_ok;
    wsum        = {1'b0, wptr_q} + sum_w'(enq_i);
    rsum        = {1'b0, rptr_q} + sum_w'(deq_i);
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | ~enq_ok;
    underflow_d = underflow_q | ~deq_ok;
    if (legal) begin
      wptr_d  = wrap(wsum);
      rptr_d  = wrap(rsum);
      count_d = count_q + cnt_w'(enq_i) - cnt_w'(deq_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Requests wider than max_add_p break the wrap arithmetic, so flag them loudly.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      a_add_range: assert ((32'(enq_i) <= max_add_lp) && (32'(deq_i) <= max_add_lp));
    end
  end

  assign wptr_r_o       = wptr_q;
  assign rptr_r_o       = rptr_q;
  assign rptr_n_o       = reset_n_i ? rptr_d : '0;
  assign count_r_o      = count_q;
  assign free_r_o       = els_cnt_lp - count_q;
  assign full_o         = (count_q == els_cnt_lp);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (32'(free_r_o) <= af_margin_lp);
  assign almost_empty_o = (32'(count_q) <= ae_margin_lp);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_bsg_fifo_tracker_multi.sv
// Directed and randomised check of bsg_fifo_tracker_multi across several depth/width
// configurations; instance 0 (els=6, max_add=3) carries the hand-worked sequence.
module tb_bsg_fifo_tracker_multi;

  localparam int NI = 5;
  localparam int ELS  [NI] = '{6, 2, 1024, 1024, 6};
  localparam int MAXA [NI] = '{3, 1, 3, 1, 1};
  localparam int AFM  [NI] = '{1, 1, 3, 0, 2};
  localparam int AEM  [NI] = '{1, 0, 2, 5, 1};

  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] enqA [NI];
  logic [31:0] deqA [NI];
  logic [31:0] wptrA [NI];
  logic [31:0] rptrA [NI];
  logic [31:0] rptrnA [NI];
  logic [31:0] countA [NI];
  logic [31:0] freeA [NI];
  logic [NI-1:0] fullA, emptyA, afA, aeA, ovA, unA;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int E  = ELS[g];
    localparam int PW = ($clog2(E) > 1) ? $clog2(E) : 1;
    localparam int CW = $clog2(E + 1);
    localparam int AW = $clog2(MAXA[g] + 1);
    logic [AW-1:0] enq, deq;
    logic [PW-1:0] wp, rp, rn;
    logic [CW-1:0] cnt, fr;
    logic fu, em, af, ae, ov, un;

    assign enq = AW'(enqA[g]);
    assign deq = AW'(deqA[g]);

    bsg_fifo_tracker_multi #(
      .els_p(E), .max_add_p(MAXA[g]),
      .almost_full_margin_p(AFM[g]), .almost_empty_margin_p(AEM[g])
    ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .enq_i(enq), .deq_i(deq),
      .wptr_r_o(wp), .rptr_r_o(rp), .rptr_n_o(rn), .count_r_o(cnt), .free_r_o(fr),
      .full_o(fu), .empty_o(em), .almost_full_o(af), .almost_empty_o(ae),
      .overflow_o(ov), .underflow_o(un)
    );

    assign wptrA[g]  = 32'(wp);
    assign rptrA[g]  = 32'(rp);
    assign rptrnA[g] = 32'(rn);
    assign countA[g] = 32'(cnt);
    assign freeA[g]  = 32'(fr);
    assign fullA[g]  = fu;
    assign emptyA[g] = em;
    assign afA[g]    = af;
    assign aeA[g]    = ae;
    assign ovA[g]    = ov;
    assign unA[g]    = un;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int e, input int d);
    enqA[0] = e;
    deqA[0] = d;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full register/flag check of instance 0 (depth 6, margins 1/1).
  task automatic checkDirected(input string tag, input int wp, input int rp, input int cnt,
                               input int ov, input int un);
    checkOutput({tag, "_wptr"}, wptrA[0], wp);
    checkOutput({tag, "_rptr"}, rptrA[0], rp);
    checkOutput({tag, "_count"}, countA[0], cnt);
    checkOutput({tag, "_free"}, freeA[0], 6 - cnt);
    checkOutput({tag, "_full"}, 32'(fullA[0]), 32'(cnt == 6));
    checkOutput({tag, "_empty"}, 32'(emptyA[0]), 32'(cnt == 0));
    checkOutput({tag, "_afull"}, 32'(afA[0]), 32'((6 - cnt) <= 1));
    checkOutput({tag, "_aempty"}, 32'(aeA[0]), 32'(cnt <= 1));
    checkOutput({tag, "_ovf"}, 32'(ovA[0]), ov);
    checkOutput({tag, "_unf"}, 32'(unA[0]), un);
  endtask

  int mW [NI];
  int mR [NI];
  int mC [NI];
  int e  [NI];
  int d  [NI];

  initial begin
    $display("[TB] start");
    for (int i = 0; i < NI; i++) begin
      enqA[i] = 0;
      deqA[i] = 0;
    end
    reset_n = 1'b0;
    tick();
    tick();
    checkDirected("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    applyStimulus(3, 0); tick(); checkDirected("enq3a", 3, 0, 3, 0, 0);
    applyStimulus(3, 0); tick(); checkDirected("enq3b", 0, 0, 6, 0, 0);
    applyStimulus(0, 3); tick(); checkDirected("deq3", 0, 3, 3, 0, 0);
    applyStimulus(2, 0); tick(); checkDirected("enq2", 2, 3, 5, 0, 0);

    applyStimulus(2, 1);
    checkOutput("ovf_rptr_n", rptrnA[0], 3);
    tick(); checkDirected("ovf", 2, 3, 5, 1, 0);
    applyStimulus(0, 1); tick(); checkDirected("ovf_sticky", 2, 4, 4, 1, 0);
    applyStimulus(1, 1); tick(); checkDirected("setup", 3, 5, 4, 1, 0);

    applyStimulus(2, 3);
    checkOutput("simul_rptr_n", rptrnA[0], 2);
    tick(); checkDirected("simul", 5, 2, 3, 1, 0);

    applyStimulus(0, 2); tick(); checkDirected("deq2", 5, 4, 1, 1, 0);
    applyStimulus(0, 2);
    checkOutput("unf_rptr_n", rptrnA[0], 4);
    tick(); checkDirected("unf", 5, 4, 1, 1, 1);

    reset_n = 1'b0;
    applyStimulus(3, 1);
    checkOutput("midrst_rptr_n", rptrnA[0], 0);
    tick(); checkDirected("midrst", 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    applyStimulus(1, 1); tick(); checkDirected("empty_eq", 0, 0, 0, 0, 1);

    reset_n = 1'b0;
    applyStimulus(0, 0); tick();
    reset_n = 1'b1;
    applyStimulus(3, 0); tick();
    applyStimulus(3, 0); tick();
    applyStimulus(1, 1); tick(); checkDirected("full_eq", 0, 0, 6, 1, 0);

    reset_n = 1'b0;
    applyStimulus(0, 0); tick();
    reset_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      mW[i] = 0;
      mR[i] = 0;
      mC[i] = 0;
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        int elim, dlim;
        elim = (MAXA[i] < ELS[i] - mC[i]) ? MAXA[i] : ELS[i] - mC[i];
        dlim = (MAXA[i] < mC[i]) ? MAXA[i] : mC[i];
        e[i] = int'($urandom_range(elim, 0));
        d[i] = int'($urandom_range(dlim, 0));
        enqA[i] = e[i];
        deqA[i] = d[i];
      end
      #2;
      for (int i = 0; i < NI; i++)
        checkOutput($sformatf("rnd%0d_rptr_n", i), rptrnA[i], (mR[i] + d[i]) % ELS[i]);
      tick();
      for (int i = 0; i < NI; i++) begin
        mW[i] = (mW[i] + e[i]) % ELS[i];
        mR[i] = (mR[i] + d[i]) % ELS[i];
        mC[i] = mC[i] + e[i] - d[i];
        checkOutput($sformatf("rnd%0d_wptr", i), wptrA[i], mW[i]);
        checkOutput($sformatf("rnd%0d_rptr", i), rptrA[i], mR[i]);
        checkOutput($sformatf("rnd%0d_count", i), countA[i], mC[i]);
        checkOutput($sformatf("rnd%0d_free", i), freeA[i], ELS[i] - mC[i]);
        checkOutput($sformatf("rnd%0d_full", i), 32'(fullA[i]), 32'(mC[i] == ELS[i]));
        checkOutput($sformatf("rnd%0d_empty", i), 32'(emptyA[i]), 32'(mC[i] == 0));
        checkOutput($sformatf("rnd%0d_afull", i), 32'(afA[i]), 32'((ELS[i] - mC[i]) <= AFM[i]));
        checkOutput($sformatf("rnd%0d_aempty", i), 32'(aeA[i]), 32'(mC[i] <= AEM[i]));
        checkOutput($sformatf("rnd%0d_err", i), 32'({ovA[i], unA[i]}), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_tracker_multi.md
Name: bsg_fifo_tracker_multi

Overview:
- Pointer and occupancy tracker for circular-buffer FIFOs, generalising the single-step tracker.
- Supports any depth (not only powers of two) and up to max_add_p enqueues and dequeues per cycle.
- Provides an explicit occupancy count, free-slot count, almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Sits beside a 1R1W or banked memory. The memory uses wptr_r_o and rptr_r_o for addressing and rptr_n_o for read-ahead.

Parameters:
- els_p, 1024, number of FIFO slots, >=2, any integer.
- max_add_p, 1, maximum enqueues and maximum dequeues per cycle, 1..els_p.
- almost_full_margin_p, 1, almost_full_o asserts when free slots <= this value.
- almost_empty_margin_p, 1, almost_empty_o asserts when count <= this value.
- Derived: ptr_w = max(1, clog2(els_p)); cnt_w = clog2(els_p+1); add_w = clog2(max_add_p+1).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; one clock; reset is synchronous and active-low.
- enq_i  in  add_w  number of elements written this cycle.
- deq_i  in  add_w  number of elements read this cycle.
- wptr_r_o  out  ptr_w  registered write pointer.
- rptr_r_o  out  ptr_w  registered read pointer.
- rptr_n_o  out  ptr_w  next-cycle read pointer (combinational).
- count_r_o  out  cnt_w  registered occupancy.
- free_r_o  out  cnt_w  els_p - count_r_o.
- full_o  out  1  count_r_o == els_p.
- empty_o  out  1  count_r_o == 0.
- almost_full_o  out  1  free_r_o <= almost_full_margin_p.
- almost_empty_o  out  1  count_r_o <= almost_empty_margin_p.
- overflow_o  out  1  sticky illegal-enqueue flag.
- underflow_o  out  1  sticky illegal-dequeue flag.

Behaviour:
- Reset (reset_n_i==0 at posedge) sets: wptr=0, rptr=0, count=0, overflow=0, underflow=0.
  - Resulting outputs: empty_o=1, full_o=0, free_r_o=els_p, almost_empty_o=1, almost_full_o=(els_p<=almost_full_margin_p).
  - Reset overrides all inputs, including mid-burst.
  - rptr_n_o reads 0 while reset_n_i is low.
- State is exactly wptr, rptr, count and the two error bits. All flags are pure decodes of registered state, so they have zero extra latency after the update edge.
- Legality is checked against registered state only:
  - Enqueue is legal iff enq_i <= free_r_o. A same-cycle dequeue does not create room.
  - Dequeue is legal iff deq_i <= count_r_o. A same-cycle enqueue cannot be dequeued.
- Legal cycle:
  - wptr <= wrap(wptr + enq_i).
  - rptr <= wrap(rptr + deq_i).
  - count <= count + enq_i - deq_i.
- wrap(x): x - els_p if x >= els_p, else x.
  - Compute the sum in ptr_w+1 bits before the compare.
  - One subtraction suffices because max_add_p <= els_p.
- Illegal cycle (either check fails):
  - Pointers and count hold; the whole cycle is discarded, including the legal half.
  - overflow_o is set if the enqueue check failed; underflow_o is set if the dequeue check failed.
  - Both error bits stay set until reset.
- rptr_n_o = wrap(rptr_r + deq_i) on a legal cycle, else rptr_r. It always equals the value rptr_r_o takes at the next edge (reset excepted).
- Simultaneous equal enq/deq on a full or empty FIFO:
  - Full with enq=k>0: illegal, since free=0.
  - Empty with deq=k>0: illegal.
- Zero-count operations (enq_i=0, deq_i=0) are always legal no-ops.
- Inputs exceeding max_add_p are out of contract. The bench must not drive them, and the RTL asserts on them in simulation.
- full_o and empty_o are never both 1.
- count_r_o always equals (wptr - rptr) mod els_p, except when full, where it is els_p.

Test Plan:
- Reset (els_p=6, max_add_p=3, margins 1/1):
  - Stimulus: hold reset_n_i=0 for 2 cycles, then release.
  - Required: ptrs=0, count=0, free=6, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, errors=0.
- Non-power-of-two wrap:
  - Stimulus: enq 3,3, then deq 3, then enq 2.
  - Required: wptr sequence 3, 0, 0, 2; rptr becomes 3; count sequence 3, 6 (full_o=1), 3, 5; almost_full_o=1 at count 5 and 6.
- Simultaneous enq/deq:
  - Stimulus: from count=4, rptr=5, wptr=3, drive enq=2 and deq=3.
  - Required: rptr_n_o=2 combinationally; next cycle rptr=2, wptr=5, count=3.
- Overflow:
  - Stimulus: at count=5, drive enq=2 with deq=1.
  - Required: no state change, overflow_o=1 and sticky. A following legal deq=1 gives count=4 with overflow_o still 1.
- Underflow:
  - Stimulus: at count=1, drive deq=2.
  - Required: underflow_o=1, count stays 1, rptr_n_o==rptr_r_o.
- Reset mid-operation and random check:
  - Stimulus: assert reset_n_i=0 while driving enq=3/deq=1.
  - Required: all state 0 and errors cleared next cycle.
  - Follow with 10k random legal cycles checked against a scoreboard model, for els_p in {2, 6, 1024} and max_add_p in {1, 3}.
